// File: rtl/onehot_stream_encoder_pkg.sv
// Shared types and helpers for onehot_stream_encoder.
// The optional out_last port is controlled by the ENC_LAST_EN macro.
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int N_DEFAULT = 4;
  // Widest request vector the helper below can scan.
  localparam int MAX_N = 32;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic int lowest_set(input logic [MAX_N-1:0] v);
    lowest_set = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/onehot_stream_encoder_if.sv
// Request-vector input and code-stream output of the encoder, bundled.
// out_last exists only when ENC_LAST_EN is defined.
interface onehot_stream_encoder_if
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
`ifdef ENC_LAST_EN
  logic         out_last;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last
  );
`else
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code
  );
`endif

endinterface

// File: rtl/onehot_stream_encoder_lsb_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus a
// nonzero flag.
module lsb_encoder
  import enc_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         nz
);

  assign idx = W'(lowest_set(MAX_N'(vec)));
  assign nz  = |vec;

endmodule

// File: rtl/onehot_stream_encoder.sv
// Captures a multi-hot request vector and emits each set bit as its binary
// index, lowest first, one per handshake. ENC_LAST_EN adds out_last.
module onehot_stream_encoder
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  onehot_stream_encoder_if.slave bus
);

  localparam int W = $clog2(N);

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] code;
  logic         pend_nz;
  logic         pend_single;
  logic         in_ready;
  logic         out_valid;

  lsb_encoder #(.N(N)) u_lsb (
    .vec (pend_q),
    .idx (code),
    .nz  (pend_nz)
  );

  // Clearing the lowest bit empties pend exactly when one bit remains.
  assign pend_single = pend_nz && ((pend_q & (pend_q - N'(1))) == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    pend_d    = pend_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // A zero vector is accepted and dropped without leaving IDLE.
        if (bus.in_valid && (bus.in_vec != '0)) begin
          pend_d  = bus.in_vec;
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (!pend_nz) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          pend_d = pend_q & ~(N'(1) << code);
          if (pend_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_code  = code;
`ifdef ENC_LAST_EN
  assign bus.out_last  = out_valid && pend_single;
`endif

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Directed bench for onehot_stream_encoder (N=4) with a code scoreboard.
// Checks out_last too when ENC_LAST_EN is defined.
module tb_onehot_stream_encoder;

  localparam int N = 4;

  typedef struct {
    logic [1:0] code;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  onehot_stream_encoder_if #(.N(N)) bus ();

  onehot_stream_encoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the codes a vector should produce, lowest index first.
  task automatic expect_vec(input logic [N-1:0] vec);
    int hi;
    hi = -1;
    for (int i = 0; i < N; i++) if (vec[i]) hi = i;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        exp_t e;
        e.code = 2'(i);
        e.last = (i == hi);
        sb.push_back(e);
      end
    end
  endtask

  // Offer a vector in IDLE; returns just after the accepting edge.
  task automatic send(input string tag, input logic [N-1:0] vec);
    bus.in_valid = 1'b1;
    bus.in_vec   = vec;
    check({tag, "_in_ready_before"}, 32'(bus.in_ready), 1);
    expect_vec(vec);
    tick();
    bus.in_valid = 1'b0;
    bus.in_vec   = 4'($urandom);
  endtask

  // Scoreboard side: every beat seen on the output must be the next expected code.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_code", 32'(bus.out_code), 32'(e.code));
`ifdef ENC_LAST_EN
        check("out_last", 32'(bus.out_last), 32'(e.last));
`endif
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_code", 32'(bus.out_code), 0);
`ifdef ENC_LAST_EN
    check("rst_out_last", 32'(bus.out_last), 0);
`endif
    rst = 1'b0;
    tick();

    // Single bit: one beat, code 2, then idle again
    bus.out_ready = 1'b1;
    send("single", 4'b0100);
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_busy", 32'(bus.in_ready), 0);
    tick();
    check("single_idle_ready", 32'(bus.in_ready), 1);
    check("single_idle_valid", 32'(bus.out_valid), 0);

    // Three bits: codes 0,1,3 on consecutive cycles, 3+1 cycles total
    send("multi", 4'b1011);
    for (int i = 0; i < 3; i++) begin
      check("multi_valid", 32'(bus.out_valid), 1);
      check("multi_busy", 32'(bus.in_ready), 0);
      tick();
    end
    check("multi_idle_ready", 32'(bus.in_ready), 1);
    check("multi_idle_valid", 32'(bus.out_valid), 0);

    // Backpressure: code 1 held stable for 3 stalled cycles
    bus.out_ready = 1'b0;
    send("stall", 4'b0110);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_code", 32'(bus.out_code), 1);
`ifdef ENC_LAST_EN
      check("stall_last", 32'(bus.out_last), 0);
`endif
      tick();
    end
    bus.out_ready = 1'b1;
    check("stall_release_code", 32'(bus.out_code), 1);
    tick();
    check("stall_second_code", 32'(bus.out_code), 2);
    tick();
    check("stall_idle_ready", 32'(bus.in_ready), 1);

    // Zero vector: accepted, no output
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check("zero_in_ready", 32'(bus.in_ready), 1);
      tick();
      check("zero_out_valid", 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;

    // Reset after two handshakes drops the remaining codes
    send("reset_mid", 4'b1111);
    tick();
    tick();
    check("pre_rst_code", 32'(bus.out_code), 2);
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 0);
    check("rst_async_code", 32'(bus.out_code), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ready", 32'(bus.in_ready), 1);
      check("post_rst_valid", 32'(bus.out_valid), 0);
    end

    // Back-to-back: second vector waits out the EMIT cycle
    send("b2b_first", 4'b1000);
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'b0001;
    check("b2b_blocked", 32'(bus.in_ready), 0);
    check("b2b_first_code", 32'(bus.out_code), 3);
    tick();
    check("b2b_gap_ready", 32'(bus.in_ready), 1);
    check("b2b_gap_valid", 32'(bus.out_valid), 0);
    expect_vec(4'b0001);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_second_valid", 32'(bus.out_valid), 1);
    check("b2b_second_code", 32'(bus.out_code), 0);
    tick();
    check("b2b_idle_ready", 32'(bus.in_ready), 1);

    tick();
    check("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
